// File: rtl/proc_mem_arbiter_if.sv
// rtl/proc_mem_arbiter_if.sv - val/rdy request and response buses around the shared-memory arbiter
interface proc_mem_arbiter_if #(
  parameter int p_req_nbits  = 77,
  parameter int p_resp_nbits = 47
);
  logic [p_req_nbits-1:0]  imemreq_msg;
  logic                    imemreq_val;
  logic                    imemreq_rdy;
  logic [p_req_nbits-1:0]  dmemreq_msg;
  logic                    dmemreq_val;
  logic                    dmemreq_rdy;
  logic [p_req_nbits-1:0]  memreq_msg;
  logic                    memreq_val;
  logic                    memreq_rdy;
  logic [p_resp_nbits-1:0] memresp_msg;
  logic                    memresp_val;
  logic                    memresp_rdy;
  logic [p_resp_nbits-1:0] imemresp_msg;
  logic                    imemresp_val;
  logic                    imemresp_rdy;
  logic [p_resp_nbits-1:0] dmemresp_msg;
  logic                    dmemresp_val;
  logic                    dmemresp_rdy;

  // master: the processor and memory around the arbiter; slave: the arbiter itself
  modport master (
    output imemreq_msg, imemreq_val, input imemreq_rdy,
    output dmemreq_msg, dmemreq_val, input dmemreq_rdy,
    input  memreq_msg,  memreq_val,  output memreq_rdy,
    output memresp_msg, memresp_val, input memresp_rdy,
    input  imemresp_msg, imemresp_val, output imemresp_rdy,
    input  dmemresp_msg, dmemresp_val, output dmemresp_rdy
  );

  modport slave (
    input  imemreq_msg, imemreq_val, output imemreq_rdy,
    input  dmemreq_msg, dmemreq_val, output dmemreq_rdy,
    output memreq_msg,  memreq_val,  input memreq_rdy,
    input  memresp_msg, memresp_val, output memresp_rdy,
    output imemresp_msg, imemresp_val, input imemresp_rdy,
    output dmemresp_msg, dmemresp_val, input dmemresp_rdy
  );
endinterface

// File: rtl/proc_mem_arbiter.sv
// rtl/proc_mem_arbiter.sv - round-robin imem/dmem arbiter onto one memory port with in-order response routing
module proc_mem_arbiter #(
  parameter int p_max_outstanding = 4,
  parameter int p_req_nbits       = 77,
  parameter int p_resp_nbits      = 47
) (
  input  logic                                   clk,
  input  logic                                   reset,
  proc_mem_arbiter_if.slave                      bus,
  output logic [$clog2(p_max_outstanding+1)-1:0] num_outstanding
);
  localparam int   p_ptr_nbits = $clog2(p_max_outstanding);
  localparam int   p_cnt_nbits = $clog2(p_max_outstanding + 1);
  localparam logic c_imem      = 1'b0;
  localparam logic c_dmem      = 1'b1;

  logic                         active;
  logic                         last_grant;
  logic                         lock;
  logic                         locked_sel;
  logic                         sel;
  logic                         sel_val;
  logic                         full;
  logic                         empty;
  logic                         head;
  logic                         memreq_val;
  logic                         memresp_rdy;
  logic                         req_fire;
  logic                         resp_fire;
  logic [p_max_outstanding-1:0] route_q;
  logic [p_ptr_nbits-1:0]       wr_ptr;
  logic [p_ptr_nbits-1:0]       rd_ptr;
  logic [p_cnt_nbits-1:0]       count;
  logic [p_req_nbits-1:0]       req_mux;
  logic [p_resp_nbits-1:0]      resp_msg;

  always_comb begin
    sel = c_imem;
    if (lock)
      sel = locked_sel;
    else if (bus.imemreq_val && bus.dmemreq_val)
      sel = ~last_grant;
    else if (bus.dmemreq_val)
      sel = c_dmem;
  end

  // active holds every val/rdy low until the first edge after reset release
  assign sel_val     = (sel == c_dmem) ? bus.dmemreq_val : bus.imemreq_val;
  assign full        = (count == p_cnt_nbits'(p_max_outstanding));
  assign empty       = (count == '0);
  assign memreq_val  = active && sel_val && !full;
  assign req_fire    = memreq_val && bus.memreq_rdy;
  assign req_mux     = (sel == c_dmem) ? bus.dmemreq_msg : bus.imemreq_msg;

  assign bus.memreq_val  = memreq_val;
  assign bus.memreq_msg  = req_mux;
  assign bus.imemreq_rdy = active && bus.memreq_rdy && !full && (sel == c_imem);
  assign bus.dmemreq_rdy = active && bus.memreq_rdy && !full && (sel == c_dmem);

  assign head        = route_q[rd_ptr];
  assign memresp_rdy = !empty && ((head == c_dmem) ? bus.dmemresp_rdy : bus.imemresp_rdy);
  assign resp_fire   = bus.memresp_val && memresp_rdy;
  assign resp_msg    = bus.memresp_msg;

  assign bus.memresp_rdy  = memresp_rdy;
  assign bus.imemresp_msg = resp_msg;
  assign bus.dmemresp_msg = resp_msg;
  assign bus.imemresp_val = !empty && (head == c_imem) && bus.memresp_val;
  assign bus.dmemresp_val = !empty && (head == c_dmem) && bus.memresp_val;

  assign num_outstanding = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= 1'b0;
      last_grant <= c_imem;
      lock       <= 1'b0;
      locked_sel <= c_imem;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      active <= 1'b1;
      // a stalled offer pins the mux; a dropped val clears the lock via memreq_val
      lock   <= memreq_val && !bus.memreq_rdy;
      if (memreq_val && !bus.memreq_rdy)
        locked_sel <= sel;
      if (req_fire) begin
        last_grant <= sel;
        wr_ptr     <= wr_ptr + p_ptr_nbits'(1);
      end
      if (resp_fire)
        rd_ptr <= rd_ptr + p_ptr_nbits'(1);
      case ({req_fire, resp_fire})
        2'b10:   count <= count + p_cnt_nbits'(1);
        2'b01:   count <= count - p_cnt_nbits'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      route_q[wr_ptr] <= sel;
  end
endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb/tb_proc_mem_arbiter.sv - randomized self-checking bench for proc_mem_arbiter
module tb_proc_mem_arbiter;
  localparam int N  = 4;
  localparam int RQ = 77;
  localparam int RS = 47;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] num_outstanding;

  proc_mem_arbiter_if #(.p_req_nbits(RQ), .p_resp_nbits(RS)) bus();

  proc_mem_arbiter #(
    .p_max_outstanding(N),
    .p_req_nbits(RQ),
    .p_resp_nbits(RS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .num_outstanding(num_outstanding)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: owner list of in-flight requests, last winner, pending stalled offer
  bit q[$];
  bit m_last;
  bit m_stall;
  bit m_stall_sel;
  bit m_active;
  bit i_hold;
  bit d_hold;
  int seen_full;
  int n_push;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RQ-1:0] rand_req();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[RQ-1:0];
  endfunction

  function automatic logic [RS-1:0] rand_resp();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[RS-1:0];
  endfunction

  task automatic cycle(input int p_req, input int p_mrdy, input int p_resp, input int p_rrdy);
    bit full, sel, exp_mval, ifire, dfire, exp_rrdy, exp_ival, exp_dval, rfire;
    @(negedge clk);
    if (!i_hold) begin
      bus.imemreq_val = ($urandom_range(99) < p_req);
      bus.imemreq_msg = rand_req();
    end
    if (!d_hold) begin
      bus.dmemreq_val = ($urandom_range(99) < p_req);
      bus.dmemreq_msg = rand_req();
    end
    bus.memreq_rdy   = ($urandom_range(99) < p_mrdy);
    bus.memresp_val  = ($urandom_range(99) < p_resp);
    bus.memresp_msg  = rand_resp();
    bus.imemresp_rdy = ($urandom_range(99) < p_rrdy);
    bus.dmemresp_rdy = ($urandom_range(99) < p_rrdy);
    #2;
    full = (q.size() == N);
    if (full) seen_full++;
    if (m_stall)                             sel = m_stall_sel;
    else if (bus.imemreq_val && bus.dmemreq_val) sel = !m_last;
    else                                     sel = bus.dmemreq_val;
    exp_mval = m_active && !full && (bus.imemreq_val || bus.dmemreq_val);
    ifire    = exp_mval && bus.memreq_rdy && !sel;
    dfire    = exp_mval && bus.memreq_rdy && sel;
    check_eq("memreq_val", 128'(bus.memreq_val), 128'(exp_mval));
    check_eq("imem_fire", 128'(bus.imemreq_val && bus.imemreq_rdy), 128'(ifire));
    check_eq("dmem_fire", 128'(bus.dmemreq_val && bus.dmemreq_rdy), 128'(dfire));
    check_eq("req_rdy_onehot", 128'(bus.imemreq_rdy && bus.dmemreq_rdy), 128'(0));
    if (exp_mval)
      check_eq("memreq_msg", 128'(bus.memreq_msg), 128'(sel ? bus.dmemreq_msg : bus.imemreq_msg));
    check_eq("num_outstanding", 128'(num_outstanding), 128'(q.size()));
    if (q.size() == 0) begin
      exp_rrdy = 1'b0; exp_ival = 1'b0; exp_dval = 1'b0;
    end else begin
      exp_rrdy = q[0] ? bus.dmemresp_rdy : bus.imemresp_rdy;
      exp_ival = !q[0] && bus.memresp_val;
      exp_dval = q[0] && bus.memresp_val;
    end
    check_eq("memresp_rdy", 128'(bus.memresp_rdy), 128'(exp_rrdy));
    check_eq("imemresp_val", 128'(bus.imemresp_val), 128'(exp_ival));
    check_eq("dmemresp_val", 128'(bus.dmemresp_val), 128'(exp_dval));
    check_eq("imemresp_msg", 128'(bus.imemresp_msg), 128'(bus.memresp_msg));
    check_eq("dmemresp_msg", 128'(bus.dmemresp_msg), 128'(bus.memresp_msg));
    rfire = bus.memresp_val && exp_rrdy;
    @(posedge clk);
    m_active = 1'b1;
    if (ifire || dfire) begin
      q.push_back(sel);
      n_push++;
      m_last  = sel;
      m_stall = 1'b0;
    end else begin
      m_stall     = exp_mval;
      m_stall_sel = sel;
    end
    if (rfire) void'(q.pop_front());
    i_hold = bus.imemreq_val && !ifire;
    d_hold = bus.dmemreq_val && !dfire;
  endtask

  task automatic check_in_reset(input string tag);
    check_eq({tag, "_count"},     128'(num_outstanding),  128'(0));
    check_eq({tag, "_memreq_val"}, 128'(bus.memreq_val),  128'(0));
    check_eq({tag, "_ireq_rdy"},   128'(bus.imemreq_rdy), 128'(0));
    check_eq({tag, "_dreq_rdy"},   128'(bus.dmemreq_rdy), 128'(0));
    check_eq({tag, "_resp_rdy"},   128'(bus.memresp_rdy), 128'(0));
    check_eq({tag, "_iresp_val"},  128'(bus.imemresp_val), 128'(0));
    check_eq({tag, "_dresp_val"},  128'(bus.dmemresp_val), 128'(0));
  endtask

  task automatic model_clear();
    q.delete();
    m_last   = 1'b0;
    m_stall  = 1'b0;
    m_active = 1'b0;
    i_hold   = 1'b0;
    d_hold   = 1'b0;
  endtask

  task automatic drive_all_busy();
    bus.imemreq_val  = 1'b1;
    bus.dmemreq_val  = 1'b1;
    bus.memreq_rdy   = 1'b1;
    bus.memresp_val  = 1'b1;
    bus.imemresp_rdy = 1'b1;
    bus.dmemresp_rdy = 1'b1;
  endtask

  initial begin
    seen_full = 0;
    n_push    = 0;
    model_clear();
    bus.imemreq_msg = '0;
    bus.dmemreq_msg = '0;
    bus.memresp_msg = '0;
    reset = 1'b0;
    drive_all_busy();
    repeat (3) @(posedge clk);
    #1;
    check_in_reset("reset");
    reset = 1'b1;

    // first cycle after release is still quiet; the next one gives the tie to DMEM
    cycle(100, 100, 100, 100);
    cycle(100, 100, 0, 100);
    check_eq("first_tie_dmem", 128'(q.size() > 0 ? q[0] : 1'b0), 128'(1));

    repeat (150) cycle(70, 70, 60, 70);
    repeat (150) cycle(90, 90, 5, 50);
    repeat (150) cycle(50, 40, 80, 30);
    repeat (40)  cycle(100, 100, 0, 100);

    // asynchronous reset between edges with requests still outstanding
    @(negedge clk);
    #1;
    drive_all_busy();
    reset = 1'b0;
    #1;
    model_clear();
    check_in_reset("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(100, 100, 100, 100);

    repeat (300) cycle(60, 60, 50, 60);

    check_eq("hit_full", 128'(seen_full > 0), 128'(1));
    check_eq("traffic_seen", 128'(n_push > 50), 128'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
Shares one memory port between the processor's instruction-memory and data-memory request streams. Used when a core connects to a single-ported memory or cache.
- Requests: round-robin arbitration, with the grant locked while a presented request is stalled.
- Responses: the memory returns them in order. An internal route FIFO records which requester owns each outstanding request and steers each response back to it.
- Request and response messages pass through unmodified, including the opaque field.

Parameters:
p_max_outstanding, 4, depth of the route FIFO and maximum number of in-flight memory requests (power of 2, >=2)
p_req_nbits, 77, width of mem_req_4B_t
p_resp_nbits, 47, width of mem_resp_4B_t

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
imemreq_msg  in  p_req_nbits  instruction request
imemreq_val  in  1  instruction request valid
imemreq_rdy  out  1  instruction request accepted
dmemreq_msg  in  p_req_nbits  data request
dmemreq_val  in  1  data request valid
dmemreq_rdy  out  1  data request accepted
memreq_msg  out  p_req_nbits  request to the shared memory
memreq_val  out  1  shared request valid
memreq_rdy  in  1  memory ready for a request
memresp_msg  in  p_resp_nbits  response from memory
memresp_val  in  1  response valid
memresp_rdy  out  1  response accepted
imemresp_msg  out  p_resp_nbits  response to the instruction port
imemresp_val  out  1  instruction response valid
imemresp_rdy  in  1  instruction port ready for a response
dmemresp_msg  out  p_resp_nbits  response to the data port
dmemresp_val  out  1  data response valid
dmemresp_rdy  in  1  data port ready for a response
num_outstanding  out  $clog2(p_max_outstanding+1)  number of in-flight requests

Behaviour:
- Fire: a transfer occurs on any port when val&&rdy at the rising edge.

Reset (reset==0, asynchronous):
- Route FIFO empties; num_outstanding=0.
- last_grant=IMEM, so the first tie goes to DMEM.
- lock=0.
- All val/rdy outputs are 0 while in reset and on the first cycle after release, because they are derived from the cleared state.
- Reset mid-operation discards all route entries. Responses still in flight from memory are then unroutable (see "unroutable response" below).

Request arbitration (state: last_grant {IMEM,DMEM}, lock, locked_sel):
- full = (num_outstanding == p_max_outstanding).
- If lock=1: sel=locked_sel.
- If lock=0 and only one requester is valid: sel is that requester.
- If lock=0 and both are valid: sel is the requester that is not last_grant.
- memreq_val = (imemreq_val||dmemreq_val) && !full.
- memreq_msg = message of sel (combinational mux).
- memreq_val never depends on memreq_rdy.
- imemreq_rdy = memreq_rdy && !full && sel==IMEM; dmemreq_rdy likewise for DMEM. At most one is high.
- If memreq_val && !memreq_rdy: lock<=1, locked_sel<=sel. This keeps msg stable as val/rdy requires.
- On memreq fire: lock<=0, last_grant<=sel, push sel into the route FIFO.
- full blocks new grants even if a response pops in the same cycle. There is no full-bypass.
- A locked requester is expected to hold val. If its val drops anyway, lock clears in that cycle and arbitration re-runs the next cycle.

Response routing:
- head = route FIFO head. Valid only when not empty.
- Empty FIFO: memresp_rdy=0, and imemresp_val and dmemresp_val are both 0. An unroutable response is never consumed.
- head==IMEM: imemresp_val=memresp_val, imemresp_msg=memresp_msg, memresp_rdy=imemresp_rdy; dmemresp_val=0.
- head==DMEM: the symmetric mapping applies.
- Both *resp_msg outputs are driven with memresp_msg at all times; only the val signals are steered.
- On memresp fire: pop the route FIFO.

Occupancy:
- num_outstanding += push - pop each cycle.
- Push and pop in the same cycle leave the count unchanged and are legal when not full.
- FIFO pointers are log2(p_max_outstanding) bits wide and wrap naturally.
- There is zero-cycle combinational latency through the block in both directions. There is no buffering of messages, only of route bits.

Test Plan:
1. Solo traffic: imem issues addr 0x200, 0x204 with memreq_rdy=1.
   -> Two memreq fires, each the same cycle as its imemreq_rdy; num_outstanding goes 1 then 2.
   -> Two responses return only on imemresp, in order; dmemresp_val=0 throughout.
2. Round-robin: both requesters continuously valid, memreq_rdy=1, immediate responses.
   -> Grant sequence is D,I,D,I,...
   -> Each response goes to the matching port: data 0xdead to dmem, 0xbeef to imem.
3. Lock under backpressure:
   - memreq_rdy=0 for 3 cycles with dmem valid, then imem also raises val.
   -> memreq_msg stays equal to the dmem message throughout the stall.
   - memreq_rdy=1.
   -> dmem fires first, then imem.
4. Full: p_max_outstanding=4, 4 requests issued, no responses.
   -> num_outstanding=4 and memreq_val=0 despite requesters being valid.
   - One response popped.
   -> memreq_val=1 on the next cycle.
5. Response backpressure: head=IMEM with imemresp_rdy=0 for 2 cycles while dmemresp_rdy=1.
   -> memresp_rdy=0 and no pop for those 2 cycles.
   -> After imemresp_rdy=1 the pop occurs and dmem is unaffected.
6. Async reset: assert reset=0 mid-cycle with 3 outstanding requests.
   -> num_outstanding=0 immediately, without waiting for a clock edge.
   - After release, memresp_val=1 is applied.
   -> memresp_rdy=0 and neither response port asserts val.
